snake_move_ctrl: RTL and testbench
==================================

// Module: snake_move_ctrl
// PURPOSE
// - Player-input front end for the snake game engine. It converts raw per-player direction buttons into the
//   32-bit move codes that the engine samples once per frame.
// - Processing chain: 2-flop synchroniser, debounce, press-edge detect, reversal rejection, and a pending-turn
//   register that commits on the frame tick. Sits directly upstream of the engine's move1/move2 inputs.
// - Move code encoding: 1=up, 2=right, 3=down, 4=left.
// PARAMETERS
// - DEBOUNCE_CYCLES  500000  consecutive cycles the synchronised input must differ from the stable value before
//                            the stable value flips; range 1..2^DB_W-1.
// - DB_W             20      debounce counter width.
// PORTS
// - clock     in   1   system clock, all logic on posedge
// - reset     in   1   synchronous, active-high
// - btn1      in   4   player 1 raw buttons {left,down,right,up} = bits [3:0] = {4,3,2,1}; async, active-high
// - btn2      in   4   player 2 raw buttons, same layout
// - tick      in   1   one-cycle frame-advance pulse from the engine's frame timer
// - move1     out  32  committed player 1 direction, zero-extended code 1..4
// - move2     out  32  committed player 2 direction
// - pending1  out  1   player 1 has an uncommitted turn
// - pending2  out  1   player 2 has an uncommitted turn
// BEHAVIOUR
// - Reset values: move1=2 (right), move2=4 (left), pending1=pending2=0.
//   Internal state also cleared: sync flops=0, stable=0, debounce counters=0.
// - Synchroniser: each of the 8 button bits passes through 2 flops, giving s[b].
// - Debounce, per bit:
//   - Counter increments while s!=stable and resets to 0 when s==stable.
//   - When the counter reaches DEBOUNCE_CYCLES-1 with s!=stable, stable<=s and the counter is cleared.
//   - A pulse shorter than DEBOUNCE_CYCLES synchronised cycles never changes stable.
// - Press event: rising edge of stable (stable=1, previous=0), one cycle wide.
//   Falling edges are ignored.
// - Multiple presses in one cycle for one player: only the highest priority is taken, up>right>down>left.
// - Reference direction R:
//   - If tick=1 this cycle and pending=1, R = the pending direction.
//   - Otherwise R = the committed move.
// - Acceptance: a press D is accepted iff D!=R and D is not opposite(R).
//   Opposite pairs: 1<->3, 2<->4. Rejected presses are dropped silently.
// - Pending register, single entry:
//   - An accepted press loads pend_dir<=D and pending<=1. A newer accepted press overwrites an older one.
// - Commit: on a tick cycle with pending=1, move<=pend_dir and pending<=0.
//   - On a tick with pending=0, move is unchanged.
// - Same-cycle tick and press:
//   - The old pending commits.
//   - The press is checked against the newly committed value, using R as defined above.
//   - If accepted, the press becomes the new pending (pending stays 1).
// - Latency, raw edge to pending=1: 2 + DEBOUNCE_CYCLES + 1 cycles.
//   Pending to move: the first tick edge.
// - Players are fully independent; no cross-player interaction.
// - Reset mid-debounce discards all progress.
//   A button held through reset produces a press DEBOUNCE_CYCLES+3 cycles after reset deasserts.
// - move outputs change only on tick cycles or reset.
// CONFIGURATION
// - SNAKE_MOVE_TURN_BUF_EN defined: the pending register becomes a 2-deep FIFO per player.
//   - pendingN = FIFO non-empty.
//   - Acceptance reference is the last queued entry. If the FIFO is empty, the reference is R as above.
//   - A press arriving while the FIFO is full (2 entries) is dropped.
//   - tick pops exactly one entry into move.
//   - On the same cycle, pop happens before push, so a push into a full FIFO on a tick cycle succeeds.
// - SNAKE_MOVE_TURN_BUF_EN undefined: single-entry overwrite behaviour as specified above.
// TESTING (DEBOUNCE_CYCLES=4)
// 1. Reset held 3 cycles -> move1=32'd2, move2=32'd4, pending1=pending2=0.
// 2. btn1[0] held 12 cycles -> pending1=1 exactly 7 cycles after the raw edge; next tick -> move1=1, pending1=0.
// 3. move1=2, btn1[3] (left) held 12 cycles -> pending1 stays 0; tick -> move1 stays 2.
// 4. btn2[1] pulsed high 3 cycles -> no pending2; btn2 bounce 1,0,1,1,1,1 -> exactly one press event.
// 5. move1=2, press up then down (debounced, no tick between):
//    - macro off -> tick -> move1=3.
//    - macro on -> down rejected against queued up -> tick -> move1=1, pending1=0.
// 6. pending1=1 (up), tick and debounced right press in the same cycle -> move1=1, pending1=1;
//    next tick -> move1=2.

Source files
------------

// File: rtl/snake_move_ctrl.sv
// Player-input front end: sync, debounce, press detect, reversal rejection and frame-committed turns.
// Define SNAKE_MOVE_TURN_BUF_EN to turn the single pending-turn register into a 2-deep FIFO per player.
module snake_move_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned DB_W            = 20
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  btn1,
    input  logic [3:0]  btn2,
    input  logic        tick,
    output logic [31:0] move1,
    output logic [31:0] move2,
    output logic        pending1,
    output logic        pending2
);

    localparam int unsigned NP    = 2;
    localparam int unsigned NB    = 8;
    localparam int unsigned DIR_W = 3;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [NP-1:0][DIR_W-1:0] MOVE_RST = {3'd4, 3'd2};

    logic [NB-1:0]            sync1_q, sync1_d, sync2_q, sync2_d;
    logic [NB-1:0]            stable_q, stable_d, prev_q, prev_d;
    logic [NB-1:0][DB_W-1:0]  cnt_q, cnt_d;
    logic [NB-1:0]            press;
    logic [NP-1:0][DIR_W-1:0] move_q, move_d, press_dir, ref_dir;
    logic [NP-1:0]            pend_q, pend_d, accept;

    // Highest-priority pressed direction: up > right > down > left.
    function automatic logic [DIR_W-1:0] prio(input logic [3:0] v);
        logic [DIR_W-1:0] d;
        d = '0;
        if (v[3]) d = 3'd4;
        if (v[2]) d = 3'd3;
        if (v[1]) d = 3'd2;
        if (v[0]) d = 3'd1;
        return d;
    endfunction

    function automatic logic [DIR_W-1:0] opp(input logic [DIR_W-1:0] r);
        return (r > 3'd2) ? (r - 3'd2) : (r + 3'd2);
    endfunction

    always_comb begin
        sync1_d  = {btn2, btn1};
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        prev_d   = stable_q;
        for (int b = 0; b < NB; b++) begin
            if (sync2_q[b] == stable_q[b]) begin
                cnt_d[b] = '0;
            end else if (cnt_q[b] == DB_LAST) begin
                stable_d[b] = sync2_q[b];
                cnt_d[b]    = '0;
            end else begin
                cnt_d[b] = cnt_q[b] + DB_W'(1);
            end
        end
    end

    always_comb begin
        press     = stable_q & ~prev_q;
        press_dir = '0;
        accept    = '0;
        for (int p = 0; p < NP; p++) begin
            press_dir[p] = prio(press[p*4 +: 4]);
            accept[p]    = (press_dir[p] != '0) && (press_dir[p] != ref_dir[p])
                           && (press_dir[p] != opp(ref_dir[p]));
        end
    end

`ifdef SNAKE_MOVE_TURN_BUF_EN
    logic [NP-1:0][1:0][DIR_W-1:0] fifo_q, fifo_d;
    logic [NP-1:0][1:0]            fcnt_q, fcnt_d;

    // Reference is the newest queued turn; with the FIFO empty it is the committed move.
    always_comb begin
        ref_dir = move_q;
        for (int p = 0; p < NP; p++) begin
            if (fcnt_q[p] == 2'd2)      ref_dir[p] = fifo_q[p][1];
            else if (fcnt_q[p] == 2'd1) ref_dir[p] = fifo_q[p][0];
        end
    end

    // Pop on tick first so a push into a full FIFO on a tick cycle still fits.
    always_comb begin
        move_d = move_q;
        fifo_d = fifo_q;
        fcnt_d = fcnt_q;
        pend_d = '0;
        for (int p = 0; p < NP; p++) begin
            if (tick && (fcnt_q[p] != 2'd0)) begin
                move_d[p]    = fifo_q[p][0];
                fifo_d[p][0] = fifo_q[p][1];
                fcnt_d[p]    = fcnt_q[p] - 2'd1;
            end
            if (accept[p] && (fcnt_d[p] != 2'd2)) begin
                fifo_d[p][fcnt_d[p][0]] = press_dir[p];
                fcnt_d[p]               = fcnt_d[p] + 2'd1;
            end
            pend_d[p] = (fcnt_d[p] != 2'd0);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fifo_q <= '0;
            fcnt_q <= '0;
        end else begin
            fifo_q <= fifo_d;
            fcnt_q <= fcnt_d;
        end
    end
`else
    logic [NP-1:0][DIR_W-1:0] pdir_q, pdir_d;

    always_comb begin
        for (int p = 0; p < NP; p++) begin
            ref_dir[p] = (tick && pend_q[p]) ? pdir_q[p] : move_q[p];
        end
    end

    // Commit the old pending turn on tick, then let an accepted press overwrite it.
    always_comb begin
        move_d = move_q;
        pend_d = pend_q;
        pdir_d = pdir_q;
        for (int p = 0; p < NP; p++) begin
            if (tick && pend_q[p]) begin
                move_d[p] = pdir_q[p];
                pend_d[p] = 1'b0;
            end
            if (accept[p]) begin
                pdir_d[p] = press_dir[p];
                pend_d[p] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) pdir_q <= '0;
        else       pdir_q <= pdir_d;
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            prev_q   <= '0;
            cnt_q    <= '0;
            move_q   <= MOVE_RST;
            pend_q   <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            prev_q   <= prev_d;
            cnt_q    <= cnt_d;
            move_q   <= move_d;
            pend_q   <= pend_d;
        end
    end

    assign move1    = 32'(move_q[0]);
    assign move2    = 32'(move_q[1]);
    assign pending1 = pend_q[0];
    assign pending2 = pend_q[1];

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Directed vector bench for snake_move_ctrl with DEBOUNCE_CYCLES=4.
module tb_snake_move_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  btn1  = 4'd0;
    logic [3:0]  btn2  = 4'd0;
    logic        tick  = 1'b0;
    logic [31:0] move1, move2;
    logic        pending1, pending2;

`ifdef SNAKE_MOVE_TURN_BUF_EN
    localparam logic [31:0] T5_MOVE = 32'd1;
`else
    localparam logic [31:0] T5_MOVE = 32'd3;
`endif

    snake_move_ctrl #(.DEBOUNCE_CYCLES(4), .DB_W(20)) dut (
        .clock(clock), .reset(reset), .btn1(btn1), .btn2(btn2), .tick(tick),
        .move1(move1), .move2(move2), .pending1(pending1), .pending2(pending2)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic [3:0]  b1;
        logic [3:0]  b2;
        logic        tk;
        logic [31:0] m1;
        logic [31:0] m2;
        logic        p1;
        logic        p2;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc;

    task automatic add(input logic rst, input logic [3:0] b1, input logic [3:0] b2, input logic tk,
                       input logic [31:0] m1, input logic [31:0] m2, input logic p1, input logic p2);
        vec_t v;
        v.rst = rst; v.b1 = b1; v.b2 = b2; v.tk = tk;
        v.m1 = m1; v.m2 = m2; v.p1 = p1; v.p2 = p2;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s vec %0d: got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset held 3 cycles
        for (int i = 0; i < 3; i++) add(1, 4'h0, 4'h0, 0, 2, 4, 0, 0);
        // Up held: pending exactly 7 cycles after raw edge, then commit on tick
        for (int i = 0; i < 12; i++) add(0, 4'h1, 4'h0, 0, 2, 4, i >= 6, 0);
        add(0, 4'h0, 4'h0, 1, 1, 4, 0, 0);
        for (int i = 0; i < 8; i++) add(0, 4'h0, 4'h0, 0, 1, 4, 0, 0);
        // Reversal (left while moving right) rejected
        add(1, 4'h0, 4'h0, 0, 2, 4, 0, 0);
        for (int i = 0; i < 12; i++) add(0, 4'h8, 4'h0, 0, 2, 4, 0, 0);
        add(0, 4'h0, 4'h0, 1, 2, 4, 0, 0);
        for (int i = 0; i < 8; i++) add(0, 4'h0, 4'h0, 0, 2, 4, 0, 0);
        // Short pulse filtered, then bounced press yields one event
        for (int i = 0; i < 3; i++) add(0, 4'h0, 4'h2, 0, 2, 4, 0, 0);
        for (int i = 0; i < 8; i++) add(0, 4'h0, 4'h0, 0, 2, 4, 0, 0);
        for (int i = 0; i < 10; i++) add(0, 4'h0, (i == 1) ? 4'h0 : 4'h1, 0, 2, 4, 0, i >= 8);
        add(0, 4'h0, 4'h1, 1, 2, 1, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 4'h0, 4'h1, 0, 2, 1, 0, 0);
        for (int i = 0; i < 8; i++) add(0, 4'h0, 4'h0, 0, 2, 1, 0, 0);
        // Tick coincides with a new press: old commits, new becomes pending
        for (int i = 0; i < 10; i++) add(0, (i < 4) ? 4'h1 : 4'h3, 4'h0, 0, 2, 1, i >= 6, 0);
        add(0, 4'h3, 4'h0, 1, 1, 1, 1, 0);
        add(0, 4'h3, 4'h0, 1, 2, 1, 0, 0);
        for (int i = 0; i < 8; i++) add(0, 4'h0, 4'h0, 0, 2, 1, 0, 0);
        // Up then down with no tick between
        add(1, 4'h0, 4'h0, 0, 2, 4, 0, 0);
        for (int i = 0; i < 10; i++) add(0, (i < 2) ? 4'h1 : 4'h5, 4'h0, 0, 2, 4, i >= 6, 0);
        add(0, 4'h5, 4'h0, 1, T5_MOVE, 4, 0, 0);
        for (int i = 0; i < 8; i++) add(0, 4'h0, 4'h0, 0, T5_MOVE, 4, 0, 0);

        foreach (vecs[i]) begin
            reset = vecs[i].rst;
            btn1  = vecs[i].b1;
            btn2  = vecs[i].b2;
            tick  = vecs[i].tk;
            step();
            n_vec++;
            chk("move1", i, move1, vecs[i].m1);
            chk("move2", i, move2, vecs[i].m2);
            chk("pending1", i, 32'(pending1), 32'(vecs[i].p1));
            chk("pending2", i, 32'(pending2), 32'(vecs[i].p2));
        end

        // Reset mid-debounce with button held: press lands DEBOUNCE_CYCLES+3 cycles after release
        reset = 1'b0; tick = 1'b0; btn2 = 4'h0;
        btn1  = 4'h1;
        for (int i = 0; i < 3; i++) step();
        reset = 1'b1;
        step();
        step();
        n_vec++;
        chk("rst_move1", 0, move1, 32'd2);
        chk("rst_pending1", 0, 32'(pending1), 32'd0);
        reset = 1'b0;
        cyc = 0;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (pending1 === 1'b1) begin
                cyc = c;
                break;
            end
        end
        n_vec++;
        chk("held_thru_reset_latency", 0, 32'(cyc), 32'd7);
        tick = 1'b1;
        step();
        tick = 1'b0;
        n_vec++;
        chk("held_thru_reset_move1", 0, move1, 32'd1);
        chk("held_thru_reset_pending1", 0, 32'(pending1), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
